// File: rtl/flop_array_rf.sv
// Flip-flop register file with per-entry valid bits, independent read/write ports,
// optional read-and-invalidate, occupancy count and access-error classification.
module flop_array_rf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit RD_CLR = 1'b0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          dout,
    output logic                       rd_valid,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_EMPTY = 2'b01;
    localparam logic [1:0] ERR_WADDR = 2'b10;
    localparam logic [1:0] ERR_RADDR = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Requests are single-cycle strobes: wr/rd are accepted on every edge they are
    // high, there is no ready/backpressure, and results appear one cycle later.
    logic [DEPTH-1:0]  wsel;
    logic [DEPTH-1:0]  rsel;
    logic [DEPTH-1:0]  rd_clear;
    logic [DEPTH-1:0]  valid_nxt;
    logic              wr_ok;
    logic              rd_ok;
    logic              same;
    logic              rd_hit;
    logic              set;
    logic              cleared;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  count_nxt;
    logic [1:0]        err_nxt;

    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wsel[i] = wr && (waddr == ADDR_W'(i));
            rsel[i] = rd && (raddr == ADDR_W'(i));
        end
        wr_ok  = |wsel;
        rd_ok  = |rsel;
        same   = wr_ok && rd_ok && (waddr == raddr);
        rd_hit = rd_ok && ((|(rsel & valid)) || same);

        // Same-address write and read: the read sees the incoming data.
        rdata = din;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsel[i] && !same) begin
                rdata = mem[i];
            end
        end

        // The write wins over read-and-invalidate on the same entry.
        rd_clear  = (RD_CLR && rd_hit && !same) ? rsel : '0;
        valid_nxt = (valid | wsel) & ~rd_clear;
        set       = |(wsel & ~valid);
        cleared   = |rd_clear;
        count_nxt = count + CNT_W'(set) - CNT_W'(cleared);

        if (rd && !rd_ok) begin
            err_nxt = ERR_RADDR;
        end else if (rd && !rd_hit) begin
            err_nxt = ERR_EMPTY;
        end else if (wr && !wr_ok) begin
            err_nxt = ERR_WADDR;
        end else begin
            err_nxt = ERR_NONE;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    mem[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid    <= '0;
            count    <= '0;
            dout     <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else if (clr) begin
            valid    <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            valid    <= valid_nxt;
            count    <= count_nxt;
            rd_valid <= rd_hit;
            if (rd_hit) begin
                dout <= rdata;
            end
            error    <= (err_nxt != ERR_NONE);
            err_code <= err_nxt;
        end
    end

endmodule

// File: tb/tb_flop_array_rf.sv
// Bench for flop_array_rf: two instances (8 entries plain, 6 entries read-and-invalidate)
// share one stimulus stream and are checked against an array-based model every cycle.
module tb_flop_array_rf;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [2:0] waddr = '0;
    logic [2:0] raddr = '0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic       rv0, rv1, err0, err1;
    logic [1:0] ec0, ec1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;

    flop_array_rf #(.DATA_W(8), .DEPTH(8), .RD_CLR(1'b0)) u_rf8 (
        .clk(clk), .resetn(resetn), .clr(clr), .wr(wr), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout0), .rd_valid(rv0), .error(err0),
        .err_code(ec0), .count(cnt0)
    );

    flop_array_rf #(.DATA_W(8), .DEPTH(6), .RD_CLR(1'b1)) u_rf6 (
        .clk(clk), .resetn(resetn), .clr(clr), .wr(wr), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout1), .rd_valid(rv1), .error(err1),
        .err_code(ec1), .count(cnt1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    int         dep[2] = '{8, 6};
    bit         rcl[2] = '{1'b0, 1'b1};
    logic [7:0] m_mem[2][8];
    bit         m_valid[2][8];
    logic [7:0] m_dout[2];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int popc(input int k);
        int n = 0;
        for (int i = 0; i < dep[k]; i++) if (m_valid[k][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dout[k] = '0;
            for (int i = 0; i < 8; i++) m_valid[k][i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic c, input logic w, input logic [2:0] wa,
                              input logic [7:0] d, input logic r, input logic [2:0] ra);
        for (int k = 0; k < 2; k++) begin
            logic       rv = 1'b0;
            logic [1:0] ec = 2'b00;
            bit         wok = w && (int'(wa) < dep[k]);
            bit         rok = r && (int'(ra) < dep[k]);
            bit         byp = wok && rok && (wa == ra);
            if (c) begin
                for (int i = 0; i < 8; i++) m_valid[k][i] = 1'b0;
            end else begin
                if (r && !rok) begin
                    ec = 2'b11;
                end else if (r) begin
                    if (byp || m_valid[k][ra]) begin
                        m_dout[k] = byp ? d : m_mem[k][ra];
                        rv = 1'b1;
                        if (rcl[k] && !byp) m_valid[k][ra] = 1'b0;
                    end else begin
                        ec = 2'b01;
                    end
                end
                if (ec == 2'b00 && w && !wok) ec = 2'b10;
                if (wok) begin
                    m_mem[k][wa] = d;
                    m_valid[k][wa] = 1'b1;
                end
            end
            if (k == 0) exp_q0.push_back({m_dout[k], rv, (ec != 2'b00), ec, 4'(popc(k))});
            else        exp_q1.push_back({m_dout[k], rv, (ec != 2'b00), ec, 4'(popc(k))});
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [2:0] wa,
                         input logic [7:0] d, input logic r, input logic [2:0] ra);
        clr = c; wr = w; waddr = wa; din = d; rd = r; raddr = ra;
        @(posedge clk);
        model_step(c, w, wa, d, r, ra);
        #1;
        clr = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0) chk("rf8_cycle", {dout0, rv0, err0, ec0, cnt0}, exp_q0.pop_front());
        if (exp_q1.size() > 0) chk("rf6_cycle", {dout1, rv1, err1, ec1, 1'b0, cnt1}, exp_q1.pop_front());
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf8", {dout0, rv0, err0, ec0, cnt0}, 16'h0000);
        chk("reset_rf6", {dout1, rv1, err1, ec1, 1'b0, cnt1}, 16'h0000);
        @(negedge clk);
        resetn = 1'b1;

        drive(0, 0, 0, 8'h00, 1, 3);
        chk("empty_rd_flags", {12'h0, err0, ec0, rv0}, {12'h0, 1'b1, 2'b01, 1'b0});
        chk("empty_rd_dout", {8'h0, dout0}, 16'h0000);
        drive(0, 1, 3, 8'hA5, 0, 0);
        drive(0, 0, 0, 8'h00, 1, 3);
        chk("rd3_dout", {8'h0, dout0}, 16'h00A5);
        chk("rd3_rv", {15'h0, rv0}, 16'h0001);
        chk("rd3_cnt_rf8", {12'h0, cnt0}, 16'd1);
        chk("rd3_cnt_rf6_rdclr", {13'h0, cnt1}, 16'd0);

        drive(0, 1, 5, 8'h3C, 1, 5);
        chk("bypass_dout", {8'h0, dout0}, 16'h003C);
        chk("bypass_rv_err", {14'h0, rv0, err0}, 16'b10);
        chk("bypass_cnt_rf8", {12'h0, cnt0}, 16'd2);
        chk("bypass_cnt_rf6", {13'h0, cnt1}, 16'd1);
        drive(0, 1, 2, 8'h11, 0, 0);
        drive(0, 1, 1, 8'h22, 1, 2);
        chk("wr1_rd2_dout", {8'h0, dout0}, 16'h0011);
        chk("wr1_rd2_cnt", {12'h0, cnt0}, 16'd4);

        drive(0, 1, 7, 8'h33, 0, 0);
        chk("wr_oob_code", {13'h0, err1, ec1}, 16'b110);
        chk("wr_oob_cnt", {13'h0, cnt1}, 16'd2);
        drive(0, 0, 0, 8'h00, 1, 6);
        chk("rd_oob_code", {13'h0, err1, ec1}, 16'b111);
        chk("rd6_empty_rf8", {14'h0, ec0}, 16'b01);
        drive(0, 1, 7, 8'h44, 1, 6);
        chk("both_oob_code", {14'h0, ec1}, 16'b11);

        drive(1, 0, 0, 8'h00, 0, 0);
        chk("clr_cnt", {12'h0, cnt0}, 16'd0);
        for (int i = 0; i < 4; i++) drive(0, 1, 3'(i), 8'(8'h40 + i), 0, 0);
        chk("rdclr_fill_cnt", {13'h0, cnt1}, 16'd4);
        drive(0, 0, 0, 8'h00, 1, 2);
        chk("rdclr_rd2_dout", {8'h0, dout1}, 16'h0042);
        chk("rdclr_rd2_cnt", {13'h0, cnt1}, 16'd3);
        drive(0, 0, 0, 8'h00, 1, 2);
        chk("rdclr_rd2_again", {13'h0, err1, ec1}, 16'b101);
        drive(0, 1, 1, 8'h55, 1, 1);
        chk("rdclr_bypass_cnt", {13'h0, cnt1}, 16'd3);
        chk("rdclr_bypass_dout", {8'h0, dout1}, 16'h0055);
        drive(0, 0, 0, 8'h00, 1, 1);
        chk("rdclr_entry1_valid", {7'h0, rv1, dout1}, 16'h0155);
        chk("rdclr_entry1_cnt", {13'h0, cnt1}, 16'd2);

        drive(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 3'(i), 8'(8'h80 + i), 0, 0);
        chk("full_cnt_rf8", {12'h0, cnt0}, 16'd8);
        chk("full_cnt_rf6", {13'h0, cnt1}, 16'd6);
        drive(0, 1, 0, 8'h99, 0, 0);
        chk("rewrite_cnt", {12'h0, cnt0}, 16'd8);
        drive(0, 0, 0, 8'h00, 1, 0);
        chk("rewrite_rd0", {8'h0, dout0}, 16'h0099);
        drive(1, 1, 4, 8'hEE, 1, 0);
        chk("clr_prio_cnt", {12'h0, cnt0}, 16'd0);
        chk("clr_prio_flags", {12'h0, rv0, err0, ec0}, 16'h0000);
        chk("clr_prio_dout", {8'h0, dout0}, 16'h0099);

        drive(0, 1, 2, 8'h77, 0, 0);
        drive(0, 0, 0, 8'h00, 1, 2);
        chk("pre_reset_rv", {15'h0, rv0}, 16'h0001);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_reset_rf8", {dout0, rv0, err0, ec0, cnt0}, 16'h0000);
        chk("async_reset_rf6", {dout1, rv1, err1, ec1, 1'b0, cnt1}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 8'h00, 1, 2);
        chk("post_reset_rd", {12'h0, ec0, ec1}, 16'b0101);

        repeat (600) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q0.size() + exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flop_array_rf.md
# flop_array_rf

Parametrised flip-flop register file with per-entry valid tracking, independent read and write addresses, and optional read-and-invalidate mode. It reports occupancy and classifies access errors. It is the next-generation storage primitive for channel buffers and mailbox-style slots, generalising the 8x8 single-address flop array.

## Interface
- DATA_W, 8, entry width in bits (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of 2)
- ADDR_W, $clog2(DEPTH), address width
- RD_CLR, 0, 1 = a successful read invalidates the entry
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous invalidate-all command
- wr  in  1  write request
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- rd  in  1  read request
- raddr  in  ADDR_W  read address
- dout  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse: dout updated by a successful read
- error  out  1  one-cycle pulse: the request sampled on the previous edge failed
- err_code  out  2  00 none, 01 read of empty entry, 10 write address >= DEPTH, 11 read address >= DEPTH
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- State: DEPTH x DATA_W storage (not reset), DEPTH-bit valid vector, count register.
- Priority per edge: clr > (wr, rd evaluated independently).
- clr=1: all valid bits cleared, count := 0, wr/rd ignored, rd_valid=0, error=0, err_code=00, dout holds.
- Write, waddr < DEPTH: mem[waddr] := din, valid[waddr] := 1. Rewriting a valid entry does not change count.
- Write, waddr >= DEPTH: dropped, error=1, err_code=10.
- Read, raddr < DEPTH, entry valid (or written the same cycle): dout := data, rd_valid=1. If RD_CLR=1, valid[raddr] := 0.
- Read of invalid entry: dout holds, rd_valid=0, error=1, err_code=01.
- Read, raddr >= DEPTH: dout holds, error=1, err_code=11.
- wr and rd in the same cycle, different addresses: both performed.
- wr and rd, same in-range address: write-first bypass.
  - dout := din, rd_valid=1, no empty error even if the entry was invalid.
  - Entry ends valid with din; RD_CLR does not clear it because the write wins.
- Both wr and rd fail in one cycle: read error code reported (01/11 over 10). Error is never sticky.
- No request and no clr: rd_valid=0, error=0, err_code=00, dout holds.
- count update: count := count + set - cleared, where set = write to a previously invalid entry and cleared = RD_CLR read of a valid entry at a different address. Bounded to 0..DEPTH by construction; no wrap.

## Timing
- Reset (async assert, any time, including mid-operation): dout=0, rd_valid=0, error=0, err_code=00, count=0, all valid=0. Storage contents are unobservable after reset.
- Reset deassertion is synchronised by the integrator; the first edge after release may carry a request.
- Read latency: 1 cycle. A request sampled at edge N drives dout/rd_valid/error/err_code after edge N. These hold for exactly one cycle unless the next edge updates them; dout holds until the next successful read.
- Write visibility: a write at edge N is readable by a read sampled at edge N (bypass) and by any later read.
- count and the valid vector reflect all updates of edge N immediately after edge N.
- Back-to-back requests every cycle are supported. No stall and no backpressure.

## Test plan
- Reset, then rd raddr=3 -> error=1, err_code=01, rd_valid=0, dout=0. Write waddr=3 din=0xA5, then rd 3 -> dout=0xA5, rd_valid=1, count=1.
- Same cycle wr waddr=5 din=0x3C and rd raddr=5 on an empty entry -> dout=0x3C, rd_valid=1, error=0, count=1. Same cycle wr 1 and rd 2 (2 valid) -> both performed.
- DEPTH=6: wr waddr=7 -> error=1, err_code=10, count unchanged. rd raddr=6 -> err_code=11. wr 7 and rd 6 together -> err_code=11.
- RD_CLR=1: write entries 0..3 (count=4), rd 2 -> dout correct, count=3; rd 2 again -> err_code=01. Same-address wr+rd on entry 1 -> count stays 3, entry 1 valid.
- Fill all DEPTH entries (count=DEPTH), rewrite entry 0 -> count stays DEPTH. clr together with wr 4 and rd 0 -> count=0, no rd_valid, no error, dout unchanged.
- Assert resetn low mid-stream with a read pulse pending -> all outputs zero asynchronously. After release, rd of any address -> err_code=01.
